// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: fetch/data arbiter for one single-port memory (3-cycle)|
// | Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic c_OWNER_FETCH = 1'b0;
    localparam logic c_OWNER_DATA  = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_served;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the port that was not served last wins.
    always_comb begin
        w_grant_data = d_req;
        if (f_req && d_req) begin
            w_grant_data = (r_last_served == c_OWNER_FETCH);
        end
    end
`else
    assign w_grant_data = d_req;
`endif

    assign state = r_state;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_owner       <= c_OWNER_FETCH;
            r_last_served <= c_OWNER_FETCH;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            f_ack         <= 1'b0;
            d_ack         <= 1'b0;
            f_rdata       <= '0;
            d_rdata       <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
        end else begin
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (f_req || d_req) begin
                        r_owner       <= w_grant_data;
                        r_last_served <= w_grant_data;
                        r_addr        <= w_grant_data ? d_addr : f_addr;
                        r_we          <= w_grant_data & d_we;
                        r_wdata       <= w_grant_data ? d_wdata : '0;
                        r_state       <= ACCESS;
                        busy          <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_en    <= 1'b1;
                    mem_we    <= r_we;
                    mem_addr  <= r_addr;
                    mem_wdata <= r_wdata;
                    r_state   <= DONE;
                    busy      <= 1'b1;
                end
                DONE: begin
                    // Read data arrives one cycle after mem_en and is captured with the ack.
                    if (r_owner == c_OWNER_DATA) begin
                        d_ack <= 1'b1;
                        if (!r_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        f_ack   <= 1'b1;
                        f_rdata <= mem_rdata;
                    end
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic c_RR = 1'b1;
`else
    localparam logic c_RR = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              Reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .state     (state)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        check("rst_rdata", {f_rdata, d_rdata}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Fetch read, basic latency
        Reset = 1'b0; f_req = 1'b1; f_addr = 16'h0010; mem_rdata = 16'hBEEF;
        tick();
        check("f1_state_access", 32'(state), 32'd1);
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_mem_en_early", 32'(mem_en), 32'd0);
        tick();
        check("f1_mem_en", 32'(mem_en), 32'd1);
        check("f1_mem_addr", 32'(mem_addr), 32'h0010);
        check("f1_mem_we", 32'(mem_we), 32'd0);
        check("f1_ack_early", 32'(f_ack), 32'd0);
        check("f1_state_done", 32'(state), 32'd2);
        tick();
        check("f1_ack", 32'(f_ack), 32'd1);
        check("f1_d_ack", 32'(d_ack), 32'd0);
        check("f1_rdata", 32'(f_rdata), 32'hBEEF);
        check("f1_state_idle", 32'(state), 32'd0);
        check("f1_busy_done", 32'(busy), 32'd0);
        check("f1_mem_en_off", 32'(mem_en), 32'd0);
        f_req = 1'b0;
        tick();
        check("f1_ack_pulse", 32'(f_ack), 32'd0);

        // Data read to seed d_rdata
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; mem_rdata = 16'hCAFE;
        tick(); tick(); tick();
        check("d1_ack", 32'(d_ack), 32'd1);
        check("d1_rdata", 32'(d_rdata), 32'hCAFE);
        check("d1_f_rdata_kept", 32'(f_rdata), 32'hBEEF);
        check("d1_f_ack", 32'(f_ack), 32'd0);
        d_req = 1'b0;
        tick();

        // Data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h7FFE; d_wdata = 16'h1234; mem_rdata = 16'h5555;
        tick(); tick();
        check("w_mem_en", 32'(mem_en), 32'd1);
        check("w_mem_we", 32'(mem_we), 32'd1);
        check("w_mem_addr", 32'(mem_addr), 32'h7FFE);
        check("w_mem_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        check("w_ack", 32'(d_ack), 32'd1);
        check("w_d_rdata_kept", 32'(d_rdata), 32'hCAFE);
        check("w_mem_en_off", {30'd0, mem_en, mem_we}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Contention: data served last, so fixed picks data and round-robin picks fetch
        f_req = 1'b1; f_addr = 16'h0200; d_req = 1'b1; d_addr = 16'h0100; mem_rdata = 16'h1111;
        tick(); tick();
        check("c_first_addr", 32'(mem_addr), c_RR ? 32'h0200 : 32'h0100);
        tick();
        check("c_first_d_ack", 32'(d_ack), 32'(!c_RR));
        check("c_first_f_ack", 32'(f_ack), 32'(c_RR));
        f_req = !c_RR; d_req = c_RR; mem_rdata = 16'h2222;
        tick();
        check("c_loser_state", 32'(state), 32'd1);
        tick();
        check("c_second_addr", 32'(mem_addr), c_RR ? 32'h0100 : 32'h0200);
        tick();
        check("c_second_d_ack", 32'(d_ack), 32'(c_RR));
        check("c_second_f_ack", 32'(f_ack), 32'(!c_RR));
        check("c_d_rdata", 32'(d_rdata), c_RR ? 32'h2222 : 32'h1111);
        check("c_f_rdata", 32'(f_rdata), c_RR ? 32'h1111 : 32'h2222);
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Continuous contention for two transactions
        f_req = 1'b1; d_req = 1'b1; mem_rdata = 16'h3333;
        tick(); tick(); tick();
        check("k1_d_ack", 32'(d_ack), 32'(!c_RR));
        check("k1_f_ack", 32'(f_ack), 32'(c_RR));
        tick(); tick(); tick();
        check("k2_d_ack", 32'(d_ack), 32'd1);
        check("k2_f_ack", 32'(f_ack), 32'd0);
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Reset during ACCESS aborts the transaction
        f_req = 1'b1; f_addr = 16'h0300;
        tick();
        check("r_state_access", 32'(state), 32'd1);
        Reset = 1'b1;
        tick();
        check("r_state", 32'(state), 32'd0);
        check("r_mem_en", 32'(mem_en), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_acks", {30'd0, f_ack, d_ack}, 32'd0);
        check("r_rdata", {f_rdata, d_rdata}, 32'd0);
        tick();
        check("r_req_ignored", {29'd0, state, mem_en}, 32'd0);
        Reset = 1'b0; mem_rdata = 16'h4444;
        tick();
        check("r_new_state", 32'(state), 32'd1);
        tick();
        check("r_new_mem_en", 32'(mem_en), 32'd1);
        check("r_new_addr", 32'(mem_addr), 32'h0300);
        tick();
        check("r_new_ack", 32'(f_ack), 32'd1);
        check("r_new_rdata", 32'(f_rdata), 32'h4444);
        f_req = 1'b0;
        tick();

        // Request dropped right after being sampled still completes
        f_req = 1'b1; f_addr = 16'h0400; mem_rdata = 16'h7777;
        tick();
        f_req = 1'b0;
        tick();
        check("x_mem_en", 32'(mem_en), 32'd1);
        check("x_mem_addr", 32'(mem_addr), 32'h0400);
        tick();
        check("x_ack", 32'(f_ack), 32'd1);
        check("x_rdata", 32'(f_rdata), 32'h7777);
        tick();
        check("x_ack_once", 32'(f_ack), 32'd0);
        check("x_idle", {29'd0, state, busy}, 32'd0);
        tick();
        check("x_stay_idle", {29'd0, state, mem_en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
